shift_operand_ctrl: RTL



---
 rtl/arm_shift_pkg.sv | 18 +
 rtl/shift_special_case.sv | 95 +++++++++
 rtl/shift_operand_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/arm_shift_pkg.sv
// Shared definitions for the Operand2 shift controller.
//   - Shift-type encodings as they appear in Operand2[6:5] and on BS_Shift_Type.
//   - Controller state encoding.
package arm_shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StFetchRs = 2'b01,
    StShift   = 2'b10,
    StDone    = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/shift_special_case.sv
// Architectural shift cases that a 5-bit barrel shifter cannot express.
// Ports:
//   shift_type_i  shift type (LSL/LSR/ASR/ROR)
//   amt_i         8-bit shift amount (instruction amount zero-extended, or Rs[7:0])
//   imm_amt_i     1 = amount came from the instruction, 0 = amount came from Rs
//   rm_i, c_i     operand value and incoming carry
//   bypass_o      1 = result_o/carry_o are final and the shifter is not used
//   result_o      special-case result
//   carry_o       special-case carry-out
module shift_special_case
  import arm_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        shift_type_i,
  input  logic [7:0]        amt_i,
  input  logic              imm_amt_i,
  input  logic [DATA_W-1:0] rm_i,
  input  logic              c_i,
  output logic              bypass_o,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  localparam logic [7:0] WidthAmt = 8'(DATA_W);

  logic [DATA_W-1:0] sign_fill;
  logic              amt_zero;
  logic              amt_eq_w;
  logic              amt_gt_w;

  assign sign_fill = {DATA_W{rm_i[DATA_W-1]}};
  assign amt_zero  = (amt_i == 8'd0);
  assign amt_eq_w  = (amt_i == WidthAmt);
  assign amt_gt_w  = (amt_i > WidthAmt);

  always_comb begin
    bypass_o = 1'b0;
    result_o = '0;
    carry_o  = 1'b0;
    if (imm_amt_i) begin
      // An encoded amount of zero means #32 for LSR/ASR and RRX for ROR.
      if (amt_zero) begin
        bypass_o = 1'b1;
        unique case (shift_type_i)
          SH_LSL: begin result_o = rm_i;                     carry_o = c_i;            end
          SH_LSR: begin result_o = '0;                       carry_o = rm_i[DATA_W-1]; end
          SH_ASR: begin result_o = sign_fill;                carry_o = rm_i[DATA_W-1]; end
          SH_ROR: begin result_o = {c_i, rm_i[DATA_W-1:1]};  carry_o = rm_i[0];        end
          default: ;
        endcase
      end
    end else if (amt_zero) begin
      bypass_o = 1'b1;
      result_o = rm_i;
      carry_o  = c_i;
    end else begin
      unique case (shift_type_i)
        SH_LSL: begin
          if (amt_eq_w) begin
            bypass_o = 1'b1;
            carry_o  = rm_i[0];
          end else if (amt_gt_w) begin
            bypass_o = 1'b1;
          end
        end
        SH_LSR: begin
          if (amt_eq_w) begin
            bypass_o = 1'b1;
            carry_o  = rm_i[DATA_W-1];
          end else if (amt_gt_w) begin
            bypass_o = 1'b1;
          end
        end
        SH_ASR: begin
          if (amt_eq_w || amt_gt_w) begin
            bypass_o = 1'b1;
            result_o = sign_fill;
            carry_o  = rm_i[DATA_W-1];
          end
        end
        SH_ROR: begin
          // Nonzero multiple of 32: value unchanged, carry is the top bit.
          if (amt_i[4:0] == 5'd0) begin
            bypass_o = 1'b1;
            result_o = rm_i;
            carry_o  = rm_i[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_ctrl.sv
// Operand2 decode and barrel-shifter sequencing for ARM data-processing ops.
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   Req_Valid/Req_Ready         request handshake (ready only in idle)
//   I_Bit, Operand2, Rm_Data,   request payload, latched at accept
//   C_Flag
//   Rs_Addr, Rs_Rd_En, Rs_Data  Rs register-file read (data one cycle after strobe)
//   BS_*                        drive/return of the external combinational shifter
//   Res_Valid/Res_Ready         result handshake
//   Op2_Value, Shifter_Carry    registered result
module shift_operand_ctrl
  import arm_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              I_Bit,
  input  logic [11:0]       Operand2,
  input  logic [DATA_W-1:0] Rm_Data,
  input  logic              C_Flag,
  output logic [3:0]        Rs_Addr,
  output logic              Rs_Rd_En,
  input  logic [DATA_W-1:0] Rs_Data,
  output logic              BS_Enable,
  output logic [DATA_W-1:0] BS_Input_Bus,
  output logic [1:0]        BS_Shift_Type,
  output logic [4:0]        BS_Shift_Amt,
  output logic              BS_Cin,
  input  logic [DATA_W-1:0] BS_Output_Bus,
  input  logic              BS_Cout,
  output logic              Res_Valid,
  input  logic              Res_Ready,
  output logic [DATA_W-1:0] Op2_Value,
  output logic              Shifter_Carry
);

  ctrl_state_e       state_q, state_d;
  logic [11:0]       op2_q;
  logic              ibit_q;
  logic [DATA_W-1:0] rm_q;
  logic              c_q;
  logic [3:0]        rs_addr_q;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d;

  logic              accept;
  logic              reg_shift;
  logic [1:0]        sh_type;
  logic [7:0]        sh_amt;
  logic [DATA_W-1:0] sh_in;
  logic              sc_bypass;
  logic [DATA_W-1:0] sc_result;
  logic              sc_carry;
  logic              bypass;

  // Only the low byte of Rs carries the shift amount.
  logic unused_rs;
  assign unused_rs = ^Rs_Data[DATA_W-1:8];

  assign accept    = (state_q == StIdle) && Req_Valid;
  assign reg_shift = !ibit_q && op2_q[4];
  assign sh_type   = ibit_q ? SH_ROR : op2_q[6:5];
  assign sh_in     = ibit_q ? {{(DATA_W-8){1'b0}}, op2_q[7:0]} : rm_q;

  always_comb begin
    if (ibit_q) begin
      sh_amt = {3'b000, op2_q[11:8], 1'b0};
    end else if (reg_shift) begin
      sh_amt = Rs_Data[7:0];
    end else begin
      sh_amt = {3'b000, op2_q[11:7]};
    end
  end

  shift_special_case #(
    .DATA_W(DATA_W)
  ) u_special (
    .shift_type_i(sh_type),
    .amt_i       (sh_amt),
    .imm_amt_i   (!reg_shift),
    .rm_i        (rm_q),
    .c_i         (c_q),
    .bypass_o    (sc_bypass),
    .result_o    (sc_result),
    .carry_o     (sc_carry)
  );

  // A rotated immediate with rot=0 is just the zero-extended imm8.
  assign bypass = ibit_q ? (op2_q[11:8] == 4'd0) : sc_bypass;

  always_comb begin
    if (ibit_q) begin
      res_d   = bypass ? sh_in : BS_Output_Bus;
      carry_d = bypass ? c_q   : BS_Output_Bus[DATA_W-1];
    end else begin
      res_d   = bypass ? sc_result : BS_Output_Bus;
      carry_d = bypass ? sc_carry  : BS_Cout;
    end
  end

  always_comb begin
    state_d       = state_q;
    BS_Enable     = 1'b0;
    BS_Input_Bus  = '0;
    BS_Shift_Type = 2'b00;
    BS_Shift_Amt  = 5'd0;
    BS_Cin        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Req_Valid) begin
          state_d = (!I_Bit && Operand2[4]) ? StFetchRs : StShift;
        end
      end
      StFetchRs: state_d = StShift;
      StShift: begin
        BS_Enable     = !bypass;
        BS_Input_Bus  = sh_in;
        BS_Shift_Type = sh_type;
        BS_Shift_Amt  = sh_amt[4:0];
        BS_Cin        = c_q;
        state_d       = StDone;
      end
      StDone: begin
        if (Res_Ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      op2_q     <= '0;
      ibit_q    <= 1'b0;
      rm_q      <= '0;
      c_q       <= 1'b0;
      rs_addr_q <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op2_q  <= Operand2;
        ibit_q <= I_Bit;
        rm_q   <= Rm_Data;
        c_q    <= C_Flag;
        if (!I_Bit && Operand2[4]) begin
          rs_addr_q <= Operand2[11:8];
        end
      end
      if (state_q == StShift) begin
        res_q   <= res_d;
        carry_q <= carry_d;
      end
    end
  end

  assign Req_Ready     = (state_q == StIdle);
  assign Res_Valid     = (state_q == StDone);
  assign Rs_Rd_En      = (state_q == StFetchRs);
  assign Rs_Addr       = rs_addr_q;
  assign Op2_Value     = res_q;
  assign Shifter_Carry = carry_q;

endmodule
